// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - register map, field positions and segment encodings for seg_display_ctrl
package seg_pkg;

    // Word index taken from A[3:2]: DATA at 0x0, CTRL at 0x4, STATUS at 0x8
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BLANK_LSB  = 4;
    localparam int CTRL_BRIGHT_LSB = 8;
    localparam int CTRL_DP_LSB     = 12;

    localparam int STATUS_IDX_LSB  = 0;
    localparam int STATUS_PEND_BIT = 2;

    localparam logic [31:0] CTRL_DEFAULT = 32'h00000F01;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element n encodes hex digit n
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - combinational hex nibble to active-low seven-segment decoder
module hex7seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - memory-mapped 4-digit seven-segment scan controller, decimal points under SEG_DP_EN
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int          DIV_W    = 16,
    parameter logic [31:0] RST_CTRL = CTRL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic [6:0]  HEX,
    output logic [3:0]  HEX_Selector,
    output logic        DP
);

    logic [DIV_W-1:0] cnt;
    logic [1:0]       idx;
    logic             pending;
    logic [15:0]      data_r;
    logic [15:0]      shadow;
    logic             en_r;
    logic [3:0]       blank_r;
    logic [3:0]       bright_r;

    logic [1:0] reg_sel;
    logic       we_data;
    logic       we_ctrl;
    logic       slot_wrap;
    logic       frame_wrap;
    logic [3:0] duty_phase;
    logic       digit_on;
    logic [3:0] nibble;
    logic [6:0] seg;

    assign reg_sel    = A[3:2];
    assign we_data    = WE && (reg_sel == REG_DATA);
    assign we_ctrl    = WE && (reg_sel == REG_CTRL);
    assign slot_wrap  = &cnt;
    assign frame_wrap = slot_wrap && (idx == 2'd3);
    assign duty_phase = cnt[DIV_W-1 -: 4];
    assign digit_on   = en_r && !blank_r[idx] && (duty_phase <= bright_r);
    assign nibble     = shadow[{idx, 2'b00} +: 4];

    hex7seg_decoder u_decoder (
        .nibble (nibble),
        .seg    (seg)
    );

    // Shadow reloads only at the frame boundary so a frame is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            pending  <= 1'b0;
            data_r   <= 16'h0000;
            shadow   <= 16'h0000;
            en_r     <= RST_CTRL[CTRL_EN_BIT];
            blank_r  <= RST_CTRL[CTRL_BLANK_LSB +: 4];
            bright_r <= RST_CTRL[CTRL_BRIGHT_LSB +: 4];
        end else begin
            cnt <= cnt + 1'b1;
            if (slot_wrap) begin
                idx <= idx + 2'd1;
            end
            if (we_data) begin
                data_r <= WD[15:0];
            end
            if (frame_wrap) begin
                shadow  <= we_data ? WD[15:0] : data_r;
                pending <= 1'b0;
            end else if (we_data) begin
                pending <= 1'b1;
            end
            if (we_ctrl) begin
                en_r     <= WD[CTRL_EN_BIT];
                blank_r  <= WD[CTRL_BLANK_LSB +: 4];
                bright_r <= WD[CTRL_BRIGHT_LSB +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            HEX          <= SEG_BLANK;
            HEX_Selector <= 4'hF;
        end else if (digit_on) begin
            HEX          <= seg;
            HEX_Selector <= ~(4'b0001 << idx);
        end else begin
            HEX          <= SEG_BLANK;
            HEX_Selector <= 4'hF;
        end
    end

`ifdef SEG_DP_EN
    logic [3:0] dp_mask_r;
    logic       dp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_mask_r <= RST_CTRL[CTRL_DP_LSB +: 4];
            dp_r      <= 1'b1;
        end else begin
            if (we_ctrl) begin
                dp_mask_r <= WD[CTRL_DP_LSB +: 4];
            end
            dp_r <= digit_on ? ~dp_mask_r[idx] : 1'b1;
        end
    end

    assign DP = dp_r;
`else
    assign DP = 1'b1;
`endif

    always_comb begin
        RD = 32'h0000_0000;
        case (reg_sel)
            REG_DATA: RD[15:0] = data_r;
            REG_CTRL: begin
                RD[CTRL_EN_BIT]              = en_r;
                RD[CTRL_BLANK_LSB +: 4]      = blank_r;
                RD[CTRL_BRIGHT_LSB +: 4]     = bright_r;
`ifdef SEG_DP_EN
                RD[CTRL_DP_LSB +: 4]         = dp_mask_r;
`endif
            end
            REG_STATUS: begin
                RD[STATUS_IDX_LSB +: 2]      = idx;
                RD[STATUS_PEND_BIT]          = pending;
            end
            default: RD = 32'h0000_0000;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{WD[31:16], A[1:0]};

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - self-checking bench for seg_display_ctrl with a cycle-count reference model
module tb_seg_display_ctrl;

    localparam int DIV_W = 6;
    localparam int SLOT  = 64;
    localparam int FRAME = 256;
`ifdef SEG_DP_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000FFF1;
`else
    localparam logic [31:0] CTRL_MASK = 32'h00000FF1;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic [6:0]  HEX;
    logic [3:0]  HEX_Selector;
    logic        DP;

    seg_display_ctrl #(.DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .WD           (WD),
        .WE           (WE),
        .RD           (RD),
        .HEX          (HEX),
        .HEX_Selector (HEX_Selector),
        .DP           (DP)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Model: t counts clocks since reset; scan position is derived arithmetically from it
    int          t = 0;
    logic [15:0] m_data = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    logic        m_pending = 1'b0;
    logic [31:0] m_ctrl = 32'h00000F01;

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        int          pos;
        int          dig;
        logic        on;
        logic [6:0]  e_hex;
        logic [3:0]  e_sel;
        logic        e_dp;
        logic        wr_data;
        pos = t % SLOT;
        dig = (t / SLOT) % 4;
        on  = m_ctrl[0] && !m_ctrl[4 + dig] && ((pos / 4) <= int'(m_ctrl[11:8]));
        if (rst || !on) begin
            e_hex = 7'h7F;
            e_sel = 4'hF;
            e_dp  = 1'b1;
        end else begin
            e_hex = seg_ref(4'((m_shadow >> (4 * dig)) & 16'hF));
            e_sel = 4'hF ^ 4'(1 << dig);
`ifdef SEG_DP_EN
            e_dp  = !m_ctrl[12 + dig];
`else
            e_dp  = 1'b1;
`endif
        end
        @(posedge clk);
        if (rst) begin
            t = 0; m_data = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
            m_ctrl = 32'h00000F01 & CTRL_MASK;
        end else begin
            wr_data = WE && (A[3:2] == 2'd0);
            if (WE && A[3:2] == 2'd1) m_ctrl = WD & CTRL_MASK;
            if (wr_data) m_data = WD[15:0];
            if (t % FRAME == FRAME - 1) begin
                m_shadow  = m_data;
                m_pending = 1'b0;
            end else if (wr_data) begin
                m_pending = 1'b1;
            end
            t++;
        end
        #1;
        check("hex", {25'b0, HEX}, {25'b0, e_hex});
        check("sel", {28'b0, HEX_Selector}, {28'b0, e_sel});
        check("dp", {31'b0, DP}, {31'b0, e_dp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        WE = 1'b1;
        tick();
        WE = 1'b0;
        WD = $urandom;
    endtask

    task automatic read_chk(input logic [3:0] addr, input string tag);
        logic [31:0] e;
        A = addr;
        #1;
        case (addr[3:2])
            2'd0: e = {16'h0, m_data};
            2'd1: e = m_ctrl;
            2'd2: e = {29'h0, m_pending, 2'((t / SLOT) % 4)};
            default: e = 32'h0;
        endcase
        check(tag, RD, e);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; WE = 1'b0; A = 4'h0; WD = 32'h0;
        tick();
        tick();
        read_chk(4'h4, "ctrl_reset");
        read_chk(4'h0, "data_reset");
        read_chk(4'h8, "status_reset");
        rst = 1'b0;

        write_reg(4'h0, 32'hDEAD_12AF);
        read_chk(4'h0, "data_readback");
        read_chk(4'h8, "status_pending_first");
        idle(2 * FRAME + 10);

        while (t % FRAME != 80) tick();
        write_reg(4'h1, {16'h0, 16'($urandom)});
        read_chk(4'h8, "status_pending_mid");
        idle(100);
        read_chk(4'h8, "status_pending_hold");
        while (t % FRAME != 2) tick();
        read_chk(4'h8, "status_pending_clear");
        idle(FRAME);

        write_reg(4'h4, 32'h00000321);
        read_chk(4'h4, "ctrl_dim");
        idle(FRAME + 20);

        write_reg(4'h4, 32'h00000000);
        for (int i = 0; i < 5; i++) begin
            read_chk(4'h8, "status_idx_disabled");
            idle(SLOT);
        end

        write_reg(4'h4, 32'h00004F01);
        read_chk(4'h4, "ctrl_dp");
        idle(FRAME + 10);

        write_reg(4'hA, $urandom);
        write_reg(4'hF, $urandom);
        read_chk(4'h8, "status_ro");
        read_chk(4'hC, "reserved_zero");
        read_chk(4'h0, "data_unchanged");

        while (t % FRAME != FRAME - 1) tick();
        write_reg(4'h2, {16'h0, 16'($urandom)});
        read_chk(4'h8, "status_boundary_write");
        idle(FRAME);

        for (int i = 0; i < 2500; i++) begin
            r = $urandom % 24;
            if (r == 0) begin
                write_reg(4'($urandom), $urandom);
            end else if (r == 1) begin
                write_reg({2'b01, 2'($urandom)}, $urandom | 32'h1);
            end else if (r == 2) begin
                read_chk(4'($urandom), "rand_read");
            end else begin
                tick();
            end
        end

        write_reg(4'h0, 32'h0000_9C3B);
        write_reg(4'h4, 32'h0000_7F51);
        idle(150);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_chk(4'h0, "data_after_reset");
        read_chk(4'h4, "ctrl_after_reset");
        read_chk(4'h8, "status_after_reset");
        idle(FRAME + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
